// File: rtl/bus1_master_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus1_master_arbiter_if
// Requester-side handshake bundle for bus1_master_arbiter.
//   req0/req1     request valid, held until the matching ack
//   op0/op1       0 = read8, 1 = read16, 2 = write32, 3 = reserved
//   addr0/addr1   byte address (tag+set above the line offset)
//   wdata0/wdata1 write data, used by write32 only
//   ack0/ack1     one-cycle completion pulse
//   rdata0/rdata1 read result, read8 zero-extended
//   grant         index of the port currently owning bus1
//   busy          high while a transaction is in flight
// master: the two requesters.  slave: the arbiter.
// The bus1 tristate pins (a1/d1/c1) are physical pads and stay as plain
// ports on the arbiter.
// -----------------------------------------------------------------------------
interface bus1_master_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              req0;
  logic              req1;
  logic [1:0]        op0;
  logic [1:0]        op1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [31:0]       wdata0;
  logic [31:0]       wdata1;
  logic              ack0;
  logic              ack1;
  logic [15:0]       rdata0;
  logic [15:0]       rdata1;
  logic              grant;
  logic              busy;

  modport master (
    output req0, req1, op0, op1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata0, rdata1, grant, busy
  );

  modport slave (
    input  req0, req1, op0, op1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata0, rdata1, grant, busy
  );
endinterface

// File: rtl/bus1_master_arbiter.sv
// -----------------------------------------------------------------------------
// bus1_master_arbiter
// Shares the single CPU-to-cache bus1 port between two requesters.
// Round-robin arbitration, then the two-cycle bus1 command sequence:
//   cycle 1: c1 = command, a1 = tag+set, d1 = wdata[15:0] (write32 only)
//   cycle 2: a1 = line offset,           d1 = wdata[31:16] (write32 only)
// then waits (no timeout) for C1_RESPONSE on c1 and returns the result.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   rq     requester handshake bundle (slave side)
//   a1     bus1 address lines, Z when not driving
//   d1     bus1 data, driven only in CMD/ADDR2 for write32
//   c1     bus1 control, driven only in CMD
// DATA1_W must stay 16: each write32 half is placed on d1 whole.
// -----------------------------------------------------------------------------
module bus1_master_arbiter #(
  parameter int              ADDR1_W     = 12,
  parameter int              OFFSET_W    = 4,
  parameter int              DATA1_W     = 16,
  parameter int              CTR1_W      = 3,
  parameter logic [CTR1_W-1:0] C1_READ8    = CTR1_W'(1),
  parameter logic [CTR1_W-1:0] C1_READ16   = CTR1_W'(2),
  parameter logic [CTR1_W-1:0] C1_WRITE32  = CTR1_W'(3),
  parameter logic [CTR1_W-1:0] C1_RESPONSE = CTR1_W'(4)
) (
  input  logic                 clk,
  input  logic                 reset,
  bus1_master_arbiter_if.slave rq,
  output wire  [ADDR1_W-1:0]   a1,
  inout  wire  [DATA1_W-1:0]   d1,
  inout  wire  [CTR1_W-1:0]    c1
);

  localparam int AW = ADDR1_W + OFFSET_W;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR2, S_WAIT, S_TURN} state_t;
  typedef enum logic [1:0] {OP_READ8, OP_READ16, OP_WRITE32, OP_RSVD} op_t;

  state_t              state_q, state_d;
  op_t                 op_q, op_d;
  logic                ptr_q, ptr_d;
  logic                grant_q, grant_d;
  logic                busy_q, busy_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                ack0_q, ack0_d, ack1_q, ack1_d;
  logic [15:0]         rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [ADDR1_W-1:0]  a1_q, a1_d;
  logic [DATA1_W-1:0]  d1_q, d1_d;
  logic [CTR1_W-1:0]   c1_q, c1_d;
  logic                a1_oe_q, a1_oe_d, d1_oe_q, d1_oe_d, c1_oe_q, c1_oe_d;
  logic                win;
  logic [15:0]         rd_result;

  // Response capture lives on the falling edge so the cache has half a cycle
  // of setup before the rising edge that acts on it.
  logic                resp_seen;
  logic [DATA1_W-1:0]  resp_data;

  // All bus drivers come straight from flops, so reset releases them at once.
  assign a1 = a1_oe_q ? a1_q : {ADDR1_W{1'bz}};
  assign d1 = d1_oe_q ? d1_q : {DATA1_W{1'bz}};
  assign c1 = c1_oe_q ? c1_q : {CTR1_W{1'bz}};

  assign rq.ack0   = ack0_q;
  assign rq.ack1   = ack1_q;
  assign rq.rdata0 = rdata0_q;
  assign rq.rdata1 = rdata1_q;
  assign rq.grant  = grant_q;
  assign rq.busy   = busy_q;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      resp_seen <= 1'b0;
      resp_data <= '0;
    end else if (state_q != S_WAIT) begin
      // Cleared on the first falling edge after WAIT is left.
      resp_seen <= 1'b0;
    end else if (!resp_seen && c1 == C1_RESPONSE) begin
      resp_seen <= 1'b1;
      resp_data <= d1;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    op_d      = op_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    a1_d      = a1_q;
    d1_d      = d1_q;
    c1_d      = c1_q;
    a1_oe_d   = a1_oe_q;
    d1_oe_d   = d1_oe_q;
    c1_oe_d   = c1_oe_q;
    win       = 1'b0;
    rd_result = '0;

    case (state_q)
      S_IDLE: begin
        if (rq.req0 || rq.req1) begin
          // Lone requester wins; on a tie the pointer decides, then points at
          // the loser so it wins the next tie.
          win = (rq.req0 && rq.req1) ? ptr_q : rq.req1;
          if (rq.req0 && rq.req1) ptr_d = ~win;
          grant_d = win;
          busy_d  = 1'b1;
          op_d    = win ? op_t'(rq.op1) : op_t'(rq.op0);
          addr_d  = win ? rq.addr1 : rq.addr0;
          wdata_d = win ? rq.wdata1 : rq.wdata0;
          state_d = S_CMD;
          if (op_d != OP_RSVD) begin
            a1_oe_d = 1'b1;
            a1_d    = addr_d[AW-1:OFFSET_W];
            c1_oe_d = 1'b1;
            case (op_d)
              OP_READ16:  c1_d = C1_READ16;
              OP_WRITE32: c1_d = C1_WRITE32;
              default:    c1_d = C1_READ8;
            endcase
            d1_oe_d = (op_d == OP_WRITE32);
            d1_d    = wdata_d[15:0];
          end
        end
      end

      S_CMD: begin
        if (op_q == OP_RSVD) begin
          // Reserved op: no bus cycle at all, just complete on this edge.
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
          state_d = S_TURN;
        end else begin
          c1_oe_d = 1'b0;
          a1_d    = ADDR1_W'(addr_q[OFFSET_W-1:0]);
          d1_oe_d = (op_q == OP_WRITE32);
          d1_d    = wdata_q[31:16];
          state_d = S_ADDR2;
        end
      end

      S_ADDR2: begin
        // Release d1 so the cache can answer on it.
        d1_oe_d = 1'b0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (resp_seen) begin
          a1_oe_d   = 1'b0;
          d1_oe_d   = 1'b0;
          ack0_d    = ~grant_q;
          ack1_d    = grant_q;
          rd_result = (op_q == OP_READ8) ? {8'h00, resp_data[7:0]} : resp_data;
          if (op_q != OP_WRITE32) begin
            if (grant_q) rdata1_d = rd_result;
            else         rdata0_d = rd_result;
          end
          state_d = S_TURN;
        end
      end

      S_TURN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_READ8;
      ptr_q    <= 1'b0;
      grant_q  <= 1'b0;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      a1_q     <= '0;
      d1_q     <= '0;
      c1_q     <= '0;
      a1_oe_q  <= 1'b0;
      d1_oe_q  <= 1'b0;
      c1_oe_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      state_q  <= state_d;
      op_q     <= op_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      a1_q     <= a1_d;
      d1_q     <= d1_d;
      c1_q     <= c1_d;
      a1_oe_q  <= a1_oe_d;
      d1_oe_q  <= d1_oe_d;
      c1_oe_q  <= c1_oe_d;
    end
  end

endmodule

// File: tb/tb_bus1_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus1_master_arbiter
// Directed bench for bus1_master_arbiter: reset abort, read8, write32,
// round-robin contention, read16 with a spurious early response, reserved op.
// Released bus1 lines are pulled up, so "Z" reads back as all-ones.
// -----------------------------------------------------------------------------
module tb_bus1_master_arbiter;

  localparam logic [2:0]  C_R8   = 3'd1;
  localparam logic [2:0]  C_R16  = 3'd2;
  localparam logic [2:0]  C_W32  = 3'd3;
  localparam logic [2:0]  C_RESP = 3'd4;
  localparam logic [2:0]  CZ     = 3'h7;
  localparam logic [11:0] AZ     = 12'hFFF;
  localparam logic [15:0] DZ     = 16'hFFFF;

  logic clk;
  logic reset;

  wire [11:0] a1;
  wire [15:0] d1;
  wire [2:0]  c1;

  pullup (a1);
  pullup (d1);
  pullup (c1);

  // Cache-side drivers.
  logic        cache_d_oe;
  logic [15:0] cache_d;
  logic        cache_c_oe;
  logic [2:0]  cache_c;
  assign d1 = cache_d_oe ? cache_d : 16'bz;
  assign c1 = cache_c_oe ? cache_c : 3'bz;

  bus1_master_arbiter_if #(.ADDR_W(16)) rq ();

  bus1_master_arbiter #(
    .ADDR1_W(12), .OFFSET_W(4), .DATA1_W(16), .CTR1_W(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rq    (rq.slave),
    .a1    (a1),
    .d1    (d1),
    .c1    (c1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Cache answers for one cycle, then releases before outputs are checked.
  task automatic respond(input logic [15:0] data);
    cache_c    = C_RESP;
    cache_d    = data;
    cache_c_oe = 1'b1;
    cache_d_oe = 1'b1;
    step();
    cache_c_oe = 1'b0;
    cache_d_oe = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int last_cmd;
    int last_ack;
    int port;

    reset = 1'b1;
    rq.req0 = 1'b0; rq.req1 = 1'b0;
    rq.op0 = 2'd0;  rq.op1 = 2'd0;
    rq.addr0 = '0;  rq.addr1 = '0;
    rq.wdata0 = '0; rq.wdata1 = '0;
    cache_d_oe = 1'b0; cache_c_oe = 1'b0;
    cache_d = '0; cache_c = '0;

    // ---- reset state ----
    #2;
    check("rst_a1", a1, AZ);
    check("rst_d1", d1, DZ);
    check("rst_c1", c1, CZ);
    check("rst_ack0", rq.ack0, 0);
    check("rst_ack1", rq.ack1, 0);
    check("rst_busy", rq.busy, 0);
    check("rst_grant", rq.grant, 0);
    check("rst_rdata0", rq.rdata0, 0);
    check("rst_rdata1", rq.rdata1, 0);
    step(); step();
    reset = 1'b0;
    step();

    // ---- reset in the middle of WAIT aborts with no ack ----
    rq.req0 = 1'b1; rq.op0 = 2'd1; rq.addr0 = 16'h0042;
    step(); step(); step(); step();
    check("mw_busy", rq.busy, 1);
    check("mw_a1_driven", a1, 12'h002);
    reset = 1'b1;
    #1;
    check("mw_a1", a1, AZ);
    check("mw_d1", d1, DZ);
    check("mw_c1", c1, CZ);
    check("mw_busy_rst", rq.busy, 0);
    rq.req0 = 1'b0;
    step();
    check("mw_noack", rq.ack0, 0);
    step();
    reset = 1'b0;
    step();
    check("mw_noack2", rq.ack0, 0);
    check("mw_idle", rq.busy, 0);

    // ---- read8 port 0, addr 0x1234, response after 6 cycles ----
    rq.req0 = 1'b1; rq.op0 = 2'd0; rq.addr0 = 16'h1234;
    step();
    check("r8_c1", c1, C_R8);
    check("r8_a1", a1, 12'h123);
    check("r8_d1", d1, DZ);
    check("r8_busy", rq.busy, 1);
    check("r8_grant", rq.grant, 0);
    step();
    check("r8_a1_off", a1, 12'h004);
    check("r8_c1_rel", c1, CZ);
    repeat (4) begin
      step();
      check("r8_noack", rq.ack0, 0);
    end
    respond(16'hAB5C);
    check("r8_ack0", rq.ack0, 1);
    check("r8_ack1", rq.ack1, 0);
    check("r8_rdata0", rq.rdata0, 16'h005C);
    check("r8_a1_z", a1, AZ);
    check("r8_d1_z", d1, DZ);
    rq.req0 = 1'b0;
    step();
    check("r8_ack_pulse", rq.ack0, 0);
    check("r8_busy_end", rq.busy, 0);

    // ---- write32 port 1, addr 0x00A8, data 0xDEADBEEF ----
    rq.req1 = 1'b1; rq.op1 = 2'd2; rq.addr1 = 16'h00A8; rq.wdata1 = 32'hDEADBEEF;
    step();
    check("w32_c1", c1, C_W32);
    check("w32_a1", a1, 12'h00A);
    check("w32_d1_lo", d1, 16'hBEEF);
    check("w32_grant", rq.grant, 1);
    step();
    check("w32_a1_off", a1, 12'h008);
    check("w32_d1_hi", d1, 16'hDEAD);
    check("w32_c1_rel", c1, CZ);
    step();
    check("w32_d1_rel", d1, DZ);
    respond(16'h0000);
    check("w32_ack1", rq.ack1, 1);
    check("w32_ack0", rq.ack0, 0);
    check("w32_d1_z", d1, DZ);
    check("w32_rdata1", rq.rdata1, 16'h0000);
    rq.req1 = 1'b0;
    step();
    check("w32_ack_pulse", rq.ack1, 0);

    // ---- both ports held: grants alternate 0,1,0,1 ----
    rq.req0 = 1'b1; rq.op0 = 2'd1; rq.addr0 = 16'h0100;
    rq.req1 = 1'b1; rq.op1 = 2'd1; rq.addr1 = 16'h0200;
    last_cmd = 0;
    last_ack = 0;
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      step();
      while (c1 === CZ && waited < 20) begin
        step();
        waited++;
      end
      check("rr_cmd_timeout", (waited < 20), 1);
      port = k % 2;
      check("rr_grant", rq.grant, port);
      check("rr_c1", c1, C_R16);
      check("rr_a1", a1, port ? 12'h020 : 12'h010);
      if (k > 0) check("rr_cmd_gap", ((cyc - last_cmd) >= 5), 1);
      last_cmd = cyc;
      step(); step();
      respond(16'h1000 + 16'(k));
      check("rr_ack0", rq.ack0, (port == 0));
      check("rr_ack1", rq.ack1, (port == 1));
      check("rr_rdata", port ? rq.rdata1 : rq.rdata0, 16'h1000 + 16'(k));
      if (k > 0) check("rr_ack_gap", ((cyc - last_ack) >= 5), 1);
      last_ack = cyc;
    end
    rq.req0 = 1'b0; rq.req1 = 1'b0;
    step(); step();

    // ---- read16 with a spurious response before WAIT ----
    rq.req0 = 1'b1; rq.op0 = 2'd1; rq.addr0 = 16'h0042;
    step();
    check("r16_c1", c1, C_R16);
    check("r16_a1", a1, 12'h004);
    step();
    check("r16_a1_off", a1, 12'h002);
    cache_c = C_RESP; cache_c_oe = 1'b1;
    step();
    cache_c_oe = 1'b0;
    #1;
    check("r16_no_early_ack", rq.ack0, 0);
    step();
    check("r16_still_wait", rq.ack0, 0);
    check("r16_busy", rq.busy, 1);
    respond(16'h1F2E);
    check("r16_ack0", rq.ack0, 1);
    check("r16_rdata0", rq.rdata0, 16'h1F2E);
    rq.req0 = 1'b0;
    step(); step();

    // ---- reserved op on port 0 ----
    rq.req0 = 1'b1; rq.op0 = 2'd3; rq.addr0 = 16'h5678;
    step();
    check("op3_busy", rq.busy, 1);
    check("op3_c1", c1, CZ);
    check("op3_a1", a1, AZ);
    check("op3_d1", d1, DZ);
    check("op3_noack_yet", rq.ack0, 0);
    step();
    check("op3_ack0", rq.ack0, 1);
    check("op3_c1_quiet", c1, CZ);
    check("op3_rdata0", rq.rdata0, 16'h1F2E);
    rq.req0 = 1'b0;
    step();
    check("op3_ack_pulse", rq.ack0, 0);
    step();
    check("op3_idle", rq.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
